genius_fluxo_dados: RTL and testbench

- Datapath of the memory-sequence game (Genius-style, up to 16 rounds).
- Holds the address and round counters, a 16x4 sequence ROM, the player-move register, button edge detection, the LED display register and timer, and the play timeout timer.
- Driven by the game control unit. It returns status flags to the control unit and raw 4-bit debug values to the top level, where the 7-segment decoding is done.

---
 rtl/genius_fluxo_dados_pkg.sv | 11 +
 rtl/genius_fluxo_dados_counter.sv | 23 ++
 rtl/genius_fluxo_dados.sv | 105 ++++++++++
 tb/tb_genius_fluxo_dados.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/genius_fluxo_dados_pkg.sv
// genius_fluxo_dados_pkg: shared constants for the memory-game datapath
package genius_fluxo_dados_pkg;

    localparam int DATA_W = 4;
    localparam int TIMEOUT_CYCLES_DEF = 5000;
    localparam int LED_CYCLES_DEF = 1000;

    // Index 0 sits in the low nibble, so the sequence reads 1,2,4,8,1,...
    localparam logic [15:0][DATA_W-1:0] ROM_CONTENT = {4{4'h8, 4'h4, 4'h2, 4'h1}};

endpackage

// File: rtl/genius_fluxo_dados_counter.sv
// genius_fluxo_dados_counter: clearable up-counter that wraps or saturates at a terminal count
module genius_fluxo_dados_counter #(
    parameter int WIDTH = 4,
    parameter int MODULUS = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    // Clear beats enable; at the terminal count either hold or roll over to zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) count <= '0;
        else if (clear) count <= '0;
        else if (enable) count <= (count == LAST) ? (SATURATE ? count : '0) : count + 1'b1;
    end

endmodule

// File: rtl/genius_fluxo_dados.sv
// genius_fluxo_dados: datapath of the Genius memory game (counters, ROM, move/LED registers, timers)
module genius_fluxo_dados
    import genius_fluxo_dados_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int LED_CYCLES = LED_CYCLES_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] botoes,
    input  logic              limpaRC,
    input  logic              registraRC,
    input  logic              zeraLeds,
    input  logic              registraLeds,
    input  logic              contaCR,
    input  logic              zeraCR,
    input  logic              contaE,
    input  logic              zeraE,
    input  logic              contaT,
    output logic              enderecoIgualRodada,
    output logic              jogada_correta,
    output logic              fimC,
    output logic              fimL,
    output logic              timeout,
    output logic              jogada_feita,
    output logic              db_tem_jogada,
    output logic [DATA_W-1:0] db_contagem,
    output logic [DATA_W-1:0] db_jogada,
    output logic [DATA_W-1:0] db_memoria,
    output logic [DATA_W-1:0] db_rodada,
    output logic [DATA_W-1:0] leds,
    output logic              led_selector
);

    localparam int LED_W = $clog2(LED_CYCLES);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    logic [DATA_W-1:0] endereco, rodada, jogada, led_reg, memoria;
    logic [LED_W-1:0] led_count;
    logic [TMO_W-1:0] tmo_count;
    logic tem_jogada, tem_jogada_prev;

    genius_fluxo_dados_counter #(.WIDTH(DATA_W), .MODULUS(16)) u_endereco (
        .clock(clock), .reset(reset), .clear(zeraE), .enable(contaE), .count(endereco)
    );

    genius_fluxo_dados_counter #(.WIDTH(DATA_W), .MODULUS(16)) u_rodada (
        .clock(clock), .reset(reset), .clear(zeraCR), .enable(contaCR), .count(rodada)
    );

    genius_fluxo_dados_counter #(.WIDTH(LED_W), .MODULUS(LED_CYCLES)) u_led_timer (
        .clock(clock), .reset(reset), .clear(zeraLeds | registraLeds), .enable(led_selector),
        .count(led_count)
    );

    // Timeout only runs while the control unit asks for it; a fresh press restarts it
    genius_fluxo_dados_counter #(.WIDTH(TMO_W), .MODULUS(TIMEOUT_CYCLES), .SATURATE(1'b1)) u_timeout (
        .clock(clock), .reset(reset), .clear(zeraE | jogada_feita | !contaT), .enable(1'b1),
        .count(tmo_count)
    );

    assign memoria = ROM_CONTENT[endereco];
    assign tem_jogada = |botoes;

    // Player move register, clear wins over a simultaneous load
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) jogada <= '0;
        else if (limpaRC) jogada <= '0;
        else if (registraRC) jogada <= botoes;
    end

    // Previous button activity, used to turn a press into a single-cycle pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) tem_jogada_prev <= 1'b0;
        else tem_jogada_prev <= tem_jogada;
    end

    // LED register and display source select
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led_reg <= '0;
            led_selector <= 1'b0;
        end else if (zeraLeds) begin
            led_reg <= '0;
            led_selector <= 1'b0;
        end else if (registraLeds) begin
            led_reg <= memoria;
            led_selector <= 1'b1;
        end
    end

    assign jogada_feita = tem_jogada & ~tem_jogada_prev;
    assign enderecoIgualRodada = endereco == rodada;
    assign jogada_correta = memoria == jogada;
    assign fimC = endereco == 4'hF;
    assign fimL = led_selector && (led_count == LED_W'(LED_CYCLES - 1));
    assign timeout = tmo_count == TMO_W'(TIMEOUT_CYCLES - 1);
    assign leds = led_selector ? led_reg : botoes;
    assign db_tem_jogada = tem_jogada;
    assign db_contagem = endereco;
    assign db_jogada = jogada;
    assign db_memoria = memoria;
    assign db_rodada = rodada;

endmodule

// File: tb/tb_genius_fluxo_dados.sv
// tb_genius_fluxo_dados: directed self-checking bench for the Genius datapath
module tb_genius_fluxo_dados;

    localparam int TMO = 12;
    localparam int LEDC = 6;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [3:0] botoes = '0;
    logic limpaRC = 0, registraRC = 0, zeraLeds = 0, registraLeds = 0;
    logic contaCR = 0, zeraCR = 0, contaE = 0, zeraE = 0, contaT = 0;
    logic enderecoIgualRodada, jogada_correta, fimC, fimL, timeout, jogada_feita, db_tem_jogada;
    logic [3:0] db_contagem, db_jogada, db_memoria, db_rodada, leds;
    logic led_selector;

    int n_cmp = 0;
    int n_err = 0;

    genius_fluxo_dados #(.TIMEOUT_CYCLES(TMO), .LED_CYCLES(LEDC)) dut (
        .clock(clock), .reset(reset), .botoes(botoes),
        .limpaRC(limpaRC), .registraRC(registraRC), .zeraLeds(zeraLeds), .registraLeds(registraLeds),
        .contaCR(contaCR), .zeraCR(zeraCR), .contaE(contaE), .zeraE(zeraE), .contaT(contaT),
        .enderecoIgualRodada(enderecoIgualRodada), .jogada_correta(jogada_correta), .fimC(fimC),
        .fimL(fimL), .timeout(timeout), .jogada_feita(jogada_feita), .db_tem_jogada(db_tem_jogada),
        .db_contagem(db_contagem), .db_jogada(db_jogada), .db_memoria(db_memoria),
        .db_rodada(db_rodada), .leds(leds), .led_selector(led_selector)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int n, pulses, tem;
        #12;
        check("rst_contagem", db_contagem, 0);
        check("rst_rodada", db_rodada, 0);
        check("rst_jogada", db_jogada, 0);
        check("rst_memoria", db_memoria, 4'h1);
        check("rst_sel", led_selector, 0);
        check("rst_leds", leds, 0);
        check("rst_timeout", timeout, 0);
        check("rst_fimc", fimC, 0);
        check("rst_fiml", fimL, 0);
        check("rst_feita", jogada_feita, 0);
        check("rst_igual", enderecoIgualRodada, 1);
        check("rst_correta", jogada_correta, 0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        contaE = 1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("walk_addr%0d", i), db_contagem, i);
            check($sformatf("walk_mem%0d", i), db_memoria, 32'(4'b0001 << (i % 4)));
            check($sformatf("walk_fimc%0d", i), fimC, i == 15);
            tick();
        end
        check("walk_wrap", db_contagem, 0);
        tick(2);
        contaE = 0;
        check("move_addr", db_contagem, 2);

        botoes = 4'b0100;
        registraRC = 1;
        tick();
        registraRC = 0;
        check("move_reg", db_jogada, 4'b0100);
        check("move_ok", jogada_correta, 1);
        botoes = 4'b0001;
        registraRC = 1;
        tick();
        registraRC = 0;
        check("move_bad", jogada_correta, 0);
        check("leds_follow_btn", leds, 4'b0001);
        botoes = 4'b0100;
        registraRC = 1;
        limpaRC = 1;
        tick();
        registraRC = 0;
        limpaRC = 0;
        check("move_clear_wins", db_jogada, 0);

        botoes = 0;
        tick(2);
        botoes = 4'b0001;
        #1;
        pulses = 0;
        tem = 0;
        for (int i = 0; i < 5; i++) begin
            pulses += int'(jogada_feita);
            tem += int'(db_tem_jogada);
            tick();
        end
        check("edge_pulses", pulses, 1);
        check("edge_tem", tem, 5);
        botoes = 0;
        tick();
        botoes = 4'b0010;
        #1;
        check("edge_second", jogada_feita, 1);
        tick();
        check("edge_second_end", jogada_feita, 0);
        botoes = 0;

        zeraE = 1;
        tick();
        zeraE = 0;
        contaCR = 1;
        contaE = 1;
        tick(3);
        contaCR = 0;
        check("round_val", db_rodada, 3);
        check("round_eq", enderecoIgualRodada, 1);
        tick();
        contaE = 0;
        check("round_ne", enderecoIgualRodada, 0);
        zeraCR = 1;
        contaCR = 1;
        tick();
        zeraCR = 0;
        contaCR = 0;
        check("round_clear_wins", db_rodada, 0);

        contaE = 1;
        tick();
        contaE = 0;
        check("led_addr", db_contagem, 5);
        registraLeds = 1;
        tick();
        registraLeds = 0;
        botoes = 4'b1000;
        #1;
        check("led_val", leds, 4'b0010);
        check("led_sel", led_selector, 1);
        n = 0;
        while (!fimL && n < 50) begin
            tick();
            n++;
        end
        check("led_fiml_delay", n, LEDC - 1);
        tick();
        check("led_fiml_pulse", fimL, 0);
        zeraLeds = 1;
        tick();
        zeraLeds = 0;
        check("led_cleared", led_selector, 0);
        check("led_btn_again", leds, 4'b1000);
        botoes = 0;

        zeraE = 1;
        tick();
        zeraE = 0;
        contaT = 1;
        n = 0;
        while (!timeout && n < 100) begin
            tick();
            n++;
        end
        check("tmo_delay", n, TMO - 1);
        tick(3);
        check("tmo_hold", timeout, 1);
        botoes = 4'b0001;
        tick();
        check("tmo_press_clear", timeout, 0);
        botoes = 0;
        tick(5);
        botoes = 4'b0010;
        tick();
        n = 0;
        while (!timeout && n < 100) begin
            tick();
            n++;
        end
        check("tmo_restart", n, TMO - 1);
        contaT = 0;
        tick();
        check("tmo_off", timeout, 0);
        botoes = 0;

        contaE = 1;
        contaCR = 1;
        tick(3);
        contaE = 0;
        contaCR = 0;
        #2;
        reset = 1'b0;
        #1;
        check("async_addr", db_contagem, 0);
        check("async_round", db_rodada, 0);
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
